// File: rtl/bcd_reg_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_reg_scan_ctrl_if : start/status, RTC read and shadow-write signals    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface bcd_reg_scan_ctrl_if #(
  parameter int NREG = 7
) ();
  logic            start;
  logic            busy;
  logic            done;
  logic            rd_req;
  logic [7:0]      rd_addr;
  logic            rd_ack;
  logic [7:0]      rd_data;
  logic            bin_we;
  logic [2:0]      bin_addr;
  logic [6:0]      bin_data;
  logic [NREG-1:0] err_bcd;
  logic [NREG-1:0] err_tmo;

  modport master (
    input  start, rd_ack, rd_data,
    output busy, done, rd_req, rd_addr, bin_we, bin_addr, bin_data, err_bcd, err_tmo
  );

  modport slave (
    output start, rd_ack, rd_data,
    input  busy, done, rd_req, rd_addr, bin_we, bin_addr, bin_data, err_bcd, err_tmo
  );
endinterface
`default_nettype wire

// File: rtl/bcd_reg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_reg_scan_ctrl : scans packed-BCD RTC registers into a binary shadow   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bcd_reg_scan_ctrl #(
  parameter int         NREG      = 7,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         TIMEOUT   = 255
) (
  input  wire logic            clk,
  input  wire logic            reset,
  bcd_reg_scan_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CONV  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NREG - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [2:0] idx;
  logic [7:0] timer;
  logic [7:0] rd_byte;

  logic [3:0] tens;
  logic [3:0] units;
  logic       bad;
  logic [6:0] result;
  logic       advance;
  logic [7:0] next_addr;

  // tens*10 built from shifts so the shared conversion stays adder-only
  always_comb begin
    tens   = rd_byte[7:4];
    units  = rd_byte[3:0];
    bad    = (tens > 4'd9) || (units > 4'd9);
    result = {3'b000, units} + {2'b00, tens, 1'b0} + {tens, 3'b000};
  end

  // Leaving a register happens either after its write or on an ack timeout
  assign advance   = (state == S_WRITE) ||
                     ((state == S_WAIT) && !bus.rd_ack && (timer == TMO_LAST));
  assign next_addr = BASE_ADDR + 8'(idx) + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      timer        <= '0;
      rd_byte      <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rd_req   <= 1'b0;
      bus.rd_addr  <= '0;
      bus.bin_we   <= 1'b0;
      bus.bin_addr <= '0;
      bus.bin_data <= '0;
      bus.err_bcd  <= '0;
      bus.err_tmo  <= '0;
    end else begin
      bus.rd_req <= 1'b0;
      bus.bin_we <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.err_bcd <= '0;
            bus.err_tmo <= '0;
            idx         <= '0;
            bus.rd_req  <= 1'b1;
            bus.rd_addr <= BASE_ADDR;
            bus.busy    <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rd_ack) begin
            rd_byte <= bus.rd_data;
            state   <= S_CONV;
          end else if (timer == TMO_LAST) begin
            bus.err_tmo[idx] <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_CONV: begin
          if (bad) begin
            bus.err_bcd[idx] <= 1'b1;
          end
          bus.bin_data <= bad ? 7'd0 : result;
          bus.bin_addr <= idx;
          bus.bin_we   <= 1'b1;
          state        <= S_WRITE;
        end
        S_WRITE: begin
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase

      if (advance) begin
        if (idx == LAST_IDX) begin
          bus.done <= 1'b1;
          state    <= S_DONE;
        end else begin
          idx         <= idx + 3'd1;
          bus.rd_req  <= 1'b1;
          bus.rd_addr <= next_addr;
          state       <= S_REQ;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_reg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_reg_scan_ctrl : scoreboard bench with a scripted RTC responder     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_bcd_reg_scan_ctrl;

  localparam int         NREG      = 7;
  localparam logic [7:0] BASE_ADDR = 8'h10;
  localparam int         TIMEOUT   = 4;

  typedef struct {
    logic [2:0] a;
    logic [6:0] d;
  } wr_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;
  int   n_req;
  int   n_done;
  int   n_we;
  int   done_cyc;

  // Per-register responder script: 0 = ack in first WAIT cycle,
  // 1 = never ack (timeout), 2 = ack in REQ cycle and again 3 cycles later
  logic [7:0] plan_byte [NREG];
  int         plan_mode [NREG];
  wr_t        exp_q [$];

  bcd_reg_scan_ctrl_if #(.NREG(NREG)) bus ();

  bcd_reg_scan_ctrl #(
    .NREG      (NREG),
    .BASE_ADDR (BASE_ADDR),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] bcd_model(input logic [7:0] b);
    int t;
    int u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9) return 7'd0;
    return 7'(t * 10 + u);
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({bus.busy, bus.done, bus.rd_req, bus.bin_we, bus.rd_addr,
                bus.bin_addr, bus.bin_data, bus.err_bcd, bus.err_tmo});
  endfunction

  // Output monitor: counts strobes and pops the scoreboard on every write
  initial begin
    n_req = 0;
    n_done = 0;
    n_we = 0;
    done_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.rd_req) n_req++;
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.bin_we) begin
        wr_t e;
        n_we++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.bin_addr), 64'hFF);
        end else begin
          e = exp_q.pop_front();
          check("bin_addr", 64'(bus.bin_addr), 64'(e.a));
          check("bin_data", 64'(bus.bin_data), 64'(e.d));
        end
      end
    end
  end

  // RTC responder: follows the plan and pushes expected writes as it acks
  initial begin
    int   k;
    logic late;
    bus.rd_ack  = 1'b0;
    bus.rd_data = 8'h00;
    k = 0;
    late = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.busy) begin
        k = 0;
        late = 1'b0;
        bus.rd_ack = 1'b0;
      end else if (bus.rd_req) begin
        if (k >= NREG) begin
          check("extra_rd_req", 64'(k), 64'(NREG - 1));
        end else begin
          check("rd_addr", 64'(bus.rd_addr), 64'(BASE_ADDR + 8'(k)));
          if (late) begin
            bus.rd_ack  = 1'b1;
            bus.rd_data = 8'h77;
            late = 1'b0;
          end
          case (plan_mode[k])
            1: begin
              @(negedge clk);
              bus.rd_ack = 1'b0;
              repeat (TIMEOUT - 1) @(negedge clk);
              late = 1'b1;
            end
            2: begin
              bus.rd_ack  = 1'b1;
              bus.rd_data = 8'hFF;
              @(negedge clk);
              bus.rd_ack = 1'b0;
              repeat (2) @(negedge clk);
              bus.rd_ack  = 1'b1;
              bus.rd_data = plan_byte[k];
              exp_q.push_back('{a: 3'(k), d: bcd_model(plan_byte[k])});
              @(negedge clk);
              bus.rd_ack = 1'b0;
            end
            default: begin
              @(negedge clk);
              bus.rd_ack  = 1'b1;
              bus.rd_data = plan_byte[k];
              exp_q.push_back('{a: 3'(k), d: bcd_model(plan_byte[k])});
              @(negedge clk);
              bus.rd_ack = 1'b0;
            end
          endcase
          k++;
        end
      end
    end
  end

  task automatic set_plan_base();
    plan_byte = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h07};
    plan_mode = '{default: 0};
  endtask

  task automatic run_scan(input string name, input logic spam, input logic chk_time,
                          input logic [NREG-1:0] exp_bcd, input logic [NREG-1:0] exp_tmo);
    int   r0;
    int   d0;
    int   t_start;
    logic got;
    r0 = n_req;
    d0 = n_done;
    got = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    t_start = cyc + 1;
    @(negedge clk);
    if (!spam) bus.start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (n_done != d0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, "_done_seen"}, 64'(got), 64'd1);
    if (chk_time) check({name, "_done_cycle"}, 64'(done_cyc - t_start), 64'(4 * NREG));
    repeat (4) @(negedge clk);
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({name, "_rd_req_count"}, 64'(n_req - r0), 64'(NREG));
    check({name, "_done_count"}, 64'(n_done - d0), 64'd1);
    check({name, "_err_bcd"}, 64'(bus.err_bcd), 64'(exp_bcd));
    check({name, "_err_tmo"}, 64'(bus.err_tmo), 64'(exp_tmo));
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic abort_scan();
    int   r0;
    int   w0;
    logic found;
    found = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.bin_we && bus.bin_addr == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_write3_seen", 64'(found), 64'd1);
    #1 reset = 1'b1;
    #1 check("abort_async_outputs", all_outputs(), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r0 = n_req;
    w0 = n_we;
    repeat (12) @(negedge clk);
    check("abort_no_rd_req", 64'(n_req - r0), 64'd0);
    check("abort_no_bin_we", 64'(n_we - w0), 64'd0);
    check("abort_outputs_idle", all_outputs(), 64'd0);
    check("abort_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    set_plan_base();
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", all_outputs(), 64'd0);

    set_plan_base();
    run_scan("basic", 1'b0, 1'b1, 7'b0000000, 7'b0000000);

    set_plan_base();
    plan_byte[2] = 8'h3A;
    run_scan("bad_units", 1'b0, 1'b1, 7'b0000100, 7'b0000000);

    set_plan_base();
    plan_mode[4] = 1;
    run_scan("timeout", 1'b0, 1'b0, 7'b0000000, 7'b0010000);

    set_plan_base();
    run_scan("start_spam", 1'b1, 1'b1, 7'b0000000, 7'b0000000);

    set_plan_base();
    plan_mode[3] = 2;
    plan_byte[3] = 8'h00;
    plan_byte[6] = 8'hA0;
    run_scan("req_ack", 1'b0, 1'b0, 7'b1000000, 7'b0000000);

    set_plan_base();
    abort_scan();

    set_plan_base();
    run_scan("rescan", 1'b0, 1'b1, 7'b0000000, 7'b0000000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
